// File: rtl/aoc_graph_pkg.sv
// Shared node encoding for the graph byte-channel blocks: packed 3-character
// node names, 5-bit character codes and the ASCII bytes used on the wire.
package aoc_graph_pkg;

    localparam int NODE_CHARS    = 3;
    localparam int NODE_BIN_BITS = 5;
    localparam int NODE_WIDTH    = NODE_CHARS * NODE_BIN_BITS;

    localparam logic [NODE_BIN_BITS-1:0] MAX_CODE = 5'd25;

    typedef logic [NODE_WIDTH-1:0]    node_t;
    typedef logic [NODE_BIN_BITS-1:0] code_t;

    typedef enum logic [7:0] {
        A_CHAR     = 8'h61,
        Z_CHAR     = 8'h7A,
        COLON_CHAR = 8'h3A,
        SPACE_CHAR = 8'h20,
        LF_CHAR    = 8'h0A
    } char_t;

    // Out-of-range codes are not clamped: 'a'+c wraps in 8 bits.
    function automatic logic [7:0] code_to_char(input logic [4:0] code);
        logic [7:0] base;
        base = A_CHAR;
        return base + {3'b000, code};
    endfunction

    function automatic logic [7:0] node_char(input node_t n, input int unsigned k);
        return code_to_char(n[k*NODE_BIN_BITS +: NODE_BIN_BITS]);
    endfunction

    function automatic logic node_has_bad_code(input node_t n);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < NODE_CHARS; k++) begin
            if (n[k*NODE_BIN_BITS +: NODE_BIN_BITS] > MAX_CODE) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/edge_list_encoder.sv
// Serializes (src, dst) edges into "src: dst1 dst2 ...\n" lines, grouping
// consecutive edges with the same source, and closes the stream with a blank line.
module edge_list_encoder
    import aoc_graph_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  edge_valid,
    output logic                  edge_ready,
    input  logic [NODE_WIDTH-1:0] edge_src,
    input  logic [NODE_WIDTH-1:0] edge_dst,
    input  logic                  edge_last,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic [7:0]            byte_data,
    output logic                  encoding_done,
    output logic                  code_error
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the producer holds valid and payload stable until that edge.

    // state names the byte currently held in byte_data (byte states), or a wait/idle state.
    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] SRC0      = 4'd1;
    localparam logic [3:0] SRC1      = 4'd2;
    localparam logic [3:0] SRC2      = 4'd3;
    localparam logic [3:0] COLON     = 4'd4;
    localparam logic [3:0] SPACE     = 4'd5;
    localparam logic [3:0] DST0      = 4'd6;
    localparam logic [3:0] DST1      = 4'd7;
    localparam logic [3:0] DST2      = 4'd8;
    localparam logic [3:0] WAIT_EDGE = 4'd9;
    localparam logic [3:0] LF        = 4'd10;
    localparam logic [3:0] LF_END    = 4'd11;
    localparam logic [3:0] DONE      = 4'd12;

    logic [3:0] state;
    logic [3:0] state_d;
    node_t      src_q;
    node_t      dst_q;
    node_t      src_n;
    node_t      dst_n;
    logic       last_q;
    logic       last_n;
    logic       pend_q;
    logic       pend_n;
    logic       line_open;
    logic       open_n;
    logic       valid_d;
    logic [7:0] byte_d;
    logic       byte_accept;
    logic       edge_take;
    logic       same_src;

    assign edge_ready  = rst_n && !byte_valid && (state == IDLE || state == WAIT_EDGE);
    assign byte_accept = byte_valid && byte_ready;
    assign edge_take   = edge_valid && edge_ready;
    assign same_src    = line_open && (edge_src == src_q);

    always_comb begin
        state_d = state;
        src_n   = src_q;
        dst_n   = dst_q;
        last_n  = last_q;
        pend_n  = pend_q;
        open_n  = line_open;
        case (state)
            IDLE: begin
                if (edge_take) begin
                    src_n   = edge_src;
                    dst_n   = edge_dst;
                    last_n  = edge_last;
                    state_d = SRC0;
                end
            end
            SRC0:  if (byte_accept) state_d = SRC1;
            SRC1:  if (byte_accept) state_d = SRC2;
            SRC2:  if (byte_accept) state_d = COLON;
            COLON: if (byte_accept) state_d = SPACE;
            SPACE: if (byte_accept) state_d = DST0;
            DST0:  if (byte_accept) state_d = DST1;
            DST1:  if (byte_accept) state_d = DST2;
            DST2: begin
                if (byte_accept) begin
                    if (last_q) begin
                        state_d = LF;
                    end else begin
                        state_d = WAIT_EDGE;
                        open_n  = 1'b1;
                    end
                end
            end
            WAIT_EDGE: begin
                if (edge_take) begin
                    dst_n  = edge_dst;
                    last_n = edge_last;
                    if (same_src) begin
                        state_d = SPACE;
                    end else begin
                        // Close the current line; the new source is printed after the LF.
                        src_n   = edge_src;
                        pend_n  = 1'b1;
                        open_n  = 1'b0;
                        state_d = LF;
                    end
                end
            end
            LF: begin
                if (byte_accept) begin
                    if (pend_q) begin
                        pend_n  = 1'b0;
                        state_d = SRC0;
                    end else begin
                        state_d = LF_END;
                    end
                end
            end
            LF_END: if (byte_accept) state_d = DONE;
            DONE: begin
                state_d = IDLE;
                open_n  = 1'b0;
                last_n  = 1'b0;
                pend_n  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // The byte loaded is the one named by the next state, using the post-capture node values.
    always_comb begin
        valid_d = 1'b1;
        byte_d  = byte_data;
        case (state_d)
            SRC0:       byte_d = node_char(src_n, 0);
            SRC1:       byte_d = node_char(src_n, 1);
            SRC2:       byte_d = node_char(src_n, 2);
            COLON:      byte_d = COLON_CHAR;
            SPACE:      byte_d = SPACE_CHAR;
            DST0:       byte_d = node_char(dst_n, 0);
            DST1:       byte_d = node_char(dst_n, 1);
            DST2:       byte_d = node_char(dst_n, 2);
            LF, LF_END: byte_d = LF_CHAR;
            default:    valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            last_q        <= 1'b0;
            pend_q        <= 1'b0;
            line_open     <= 1'b0;
            byte_valid    <= 1'b0;
            byte_data     <= 8'h00;
            encoding_done <= 1'b0;
            code_error    <= 1'b0;
        end else begin
            state         <= state_d;
            src_q         <= src_n;
            dst_q         <= dst_n;
            last_q        <= last_n;
            pend_q        <= pend_n;
            line_open     <= open_n;
            byte_valid    <= valid_d;
            byte_data     <= byte_d;
            encoding_done <= (state_d == DONE);
            if (edge_take && (node_has_bad_code(edge_src) || node_has_bad_code(edge_dst))) begin
                code_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_edge_list_encoder.sv
// Scoreboarded bench for edge_list_encoder: a string-level model of the
// adjacency format fills the expected byte queue, a monitor pops on each accepted byte.
module tb_edge_list_encoder;
    import aoc_graph_pkg::*;

    localparam node_t AAA = 15'h0000;
    localparam node_t YOU = 15'h51D8;
    localparam node_t HHH = 15'h1CE7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       edge_valid = 1'b0;
    logic       edge_ready;
    node_t      edge_src = '0;
    node_t      edge_dst = '0;
    logic       edge_last = 1'b0;
    logic       byte_valid;
    logic       byte_ready = 1'b0;
    logic [7:0] byte_data;
    logic       encoding_done;
    logic       code_error;

    edge_list_encoder dut (
        .clk(clk), .rst_n(rst_n),
        .edge_valid(edge_valid), .edge_ready(edge_ready),
        .edge_src(edge_src), .edge_dst(edge_dst), .edge_last(edge_last),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .encoding_done(encoding_done), .code_error(code_error)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    node_t      st_src[$];
    node_t      st_dst[$];
    int         done_cnt = 0;
    int         exp_done = 0;
    bit         exp_err = 1'b0;
    bit         bp_mode = 1'b0;
    int         nbytes = 0;
    int         first_cyc = 0;
    int         last_cyc = 0;
    bit         held = 1'b0;
    logic [7:0] held_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit code_bad(input node_t n);
        for (int k = 0; k < NODE_CHARS; k++)
            if (n[k*5 +: 5] > 5'd25) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void push_name(input node_t n);
        for (int k = 0; k < NODE_CHARS; k++)
            exp_q.push_back(8'h61 + {3'b000, n[k*5 +: 5]});
    endfunction

    // Builds the whole text of the stream: grouped lines, then the blank-line terminator.
    function automatic void model_stream();
        for (int i = 0; i < st_src.size(); i++) begin
            if (i == 0 || st_src[i] != st_src[i-1]) begin
                if (i != 0) exp_q.push_back(8'h0A);
                push_name(st_src[i]);
                exp_q.push_back(8'h3A);
                exp_q.push_back(8'h20);
            end else begin
                exp_q.push_back(8'h20);
            end
            push_name(st_dst[i]);
            if (code_bad(st_src[i]) || code_bad(st_dst[i])) exp_err = 1'b1;
        end
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0A);
        exp_done++;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", 32'(byte_valid), 32'd1);
                check("stall_data", 32'(byte_data), 32'(held_data));
            end
            held      = byte_valid && !byte_ready;
            held_data = byte_data;
            if (byte_valid) check("edge_ready_low_while_pending", 32'(edge_ready), 32'd0);
            if (encoding_done) done_cnt++;
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_byte: got %02h expected none", byte_data);
                end else begin
                    check("byte", 32'(byte_data), 32'(exp_q.pop_front()));
                end
                if (nbytes == 0) first_cyc = cyc;
                last_cyc = cyc;
                nbytes++;
            end
        end
    end

    // ---------------- drivers ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) byte_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_edge(input node_t s, input node_t d, input logic l);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        edge_src   = s;
        edge_dst   = d;
        edge_last  = l;
        edge_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (edge_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("edge_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        edge_valid = 1'b0;
        if (ok) check("first_byte_valid", 32'(byte_valid), 32'd1);
    endtask

    task automatic run_stream(input bit bp);
        model_stream();
        nbytes  = 0;
        bp_mode = bp;
        if (!bp) byte_ready = 1'b1;
        for (int i = 0; i < st_src.size(); i++)
            send_edge(st_src[i], st_dst[i], logic'(i == st_src.size() - 1));
        for (int i = 0; i < 3000 && done_cnt < exp_done; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("done_count", 32'(done_cnt), 32'(exp_done));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("code_error", 32'(code_error), 32'(exp_err));
        exp_q.delete();
        done_cnt = exp_done;
        bp_mode  = 1'b0;
        @(posedge clk);
        #1;
        byte_ready = 1'b1;
    endtask

    function automatic node_t rnd_node();
        return {5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)), 5'($urandom_range(0, 25))};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        node_t pool[3];
        int    n;

        repeat (2) @(negedge clk);
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_byte_data", 32'(byte_data), 32'd0);
        check("rst_edge_ready", 32'(edge_ready), 32'd0);
        check("rst_encoding_done", 32'(encoding_done), 32'd0);
        check("rst_code_error", 32'(code_error), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single edge, full-rate sink
        st_src = '{AAA};
        st_dst = '{YOU};
        run_stream(1'b0);
        check("single_byte_count", 32'(nbytes), 32'd10);
        check("single_byte_span", 32'(last_cyc - first_cyc), 32'd9);

        // grouped source
        st_src = '{AAA, AAA};
        st_dst = '{YOU, HHH};
        run_stream(1'b0);

        // new source starts a new line
        st_src = '{AAA, YOU};
        st_dst = '{YOU, HHH};
        run_stream(1'b0);

        // grouped source under random backpressure
        st_src = '{AAA, AAA};
        st_dst = '{YOU, HHH};
        run_stream(1'b1);

        // out-of-range code: byte wraps to 8'h7B and code_error sticks
        st_src = '{AAA};
        st_dst = '{15'd26};
        run_stream(1'b0);

        for (int t = 0; t < 15; t++) begin
            pool[0] = rnd_node();
            pool[1] = rnd_node();
            pool[2] = rnd_node();
            n = $urandom_range(1, 5);
            st_src.delete();
            st_dst.delete();
            for (int i = 0; i < n; i++) begin
                st_src.push_back(pool[$urandom_range(0, 2)]);
                st_dst.push_back(rnd_node());
            end
            run_stream(1'($urandom_range(0, 1)));
        end

        // reset while the DST1 byte is held
        exp_q.delete();
        push_name(AAA);
        exp_q.push_back(8'h3A);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h79);
        nbytes     = 0;
        bp_mode    = 1'b0;
        byte_ready = 1'b1;
        send_edge(AAA, YOU, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        byte_ready = 1'b0;
        @(negedge clk);
        check("pre_reset_bytes", 32'(nbytes), 32'd6);
        check("pre_reset_dst1_byte", 32'(byte_data), 32'h6F);
        rst_n = 1'b0;
        #1;
        check("mid_rst_byte_valid", 32'(byte_valid), 32'd0);
        check("mid_rst_byte_data", 32'(byte_data), 32'd0);
        check("mid_rst_edge_ready", 32'(edge_ready), 32'd0);
        check("mid_rst_code_error", 32'(code_error), 32'd0);
        check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
        exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_no_bytes", 32'(nbytes), 32'd6);

        st_src = '{YOU, YOU, HHH};
        st_dst = '{HHH, AAA, YOU};
        run_stream(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_list_encoder.md
Name: edge_list_encoder

Overview:
Serializes a stream of graph edges (src node, dst node) into the puzzle's ASCII adjacency format, "src: dst1 dst2 ...\n". Consecutive edges sharing a source are grouped onto one line. The stream ends with an extra blank line, so the input decoder reading the output reports decoding_done. Used for loopback verification of the decoder and for dumping graphs from the fabric back to the host byte channel.

Parameters:
NODE_CHARS, 3, characters per node name (do not override)
NODE_BIN_BITS, 5, bits per character code (do not override)
NODE_WIDTH, NODE_CHARS*NODE_BIN_BITS, packed node width (do not override)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
edge_valid  in  1  edge offered
edge_ready  out  1  edge accepted when edge_valid && edge_ready
edge_src  in  NODE_WIDTH  source node; char k in bits [5k+4:5k], char 0 printed first
edge_dst  in  NODE_WIDTH  destination node, same packing
edge_last  in  1  marks final edge of stream
byte_valid  out  1  output byte offered
byte_ready  in  1  downstream accepts byte
byte_data  out  8  ASCII byte
encoding_done  out  1  one-cycle pulse after terminating LF is accepted
code_error  out  1  sticky; set when any accepted char code > 25

Behaviour:
- Reset state (async on rst_n low): state IDLE, line_open=0, byte_valid=0, byte_data=0, edge_ready=0, encoding_done=0, code_error=0.
- An in-flight line is discarded on reset; no partial bytes are emitted after release.
- Char code c maps to byte 8'h61+c. Separators: ':' 8'h3A, ' ' 8'h20, LF 8'h0A.
- Byte handshake: byte_data is registered. byte_valid and byte_data hold stable while byte_valid && !byte_ready. The block advances one byte per cycle when byte_ready stays high.
- edge_ready=1 only in states IDLE and WAIT_EDGE, and only when no byte is pending. The accepted edge is captured into src_q/dst_q/last_q, and its first byte is valid on the next cycle.
- FSM states: IDLE, SRC0, SRC1, SRC2, COLON, SPACE, DST0, DST1, DST2, WAIT_EDGE, LF, LF_END, DONE.
- Transitions (each byte state advances on byte accept):
  - IDLE + edge accepted → SRC0.
  - SRC0→SRC1→SRC2→COLON→SPACE→DST0→DST1→DST2.
  - After DST2: if last_q → LF; else → WAIT_EDGE (line_open=1).
  - WAIT_EDGE + edge accepted with src == src_q → SPACE; this emits " dst".
  - WAIT_EDGE + edge accepted with src != src_q → LF. After LF with !last_q and a new line pending → SRC0.
  - LF with last_q → LF_END (second LF, the blank-line terminator) → DONE.
  - DONE pulses encoding_done for one cycle → IDLE. line_open and last_q are cleared.
- The new-source compare uses the held src_q against the newly captured src. The pending-newline decision is latched at capture.
- code_error: OR of (code>25) over all six codes of each accepted edge. The emitted byte is 8'h61+c truncated to 8 bits regardless.
- edge_last on a grouped edge (same src): " dst" is emitted, then LF and LF_END.
- An empty stream is not supported; at least one edge must carry edge_last.
- Simultaneous byte accept and edge offer in WAIT_EDGE: the edge is taken only once no byte is pending (edge_ready is low that cycle).

Decomposition:
- Shared package aoc_graph_pkg holds:
  - NODE_CHARS, NODE_BIN_BITS, NODE_WIDTH, node_t.
  - The char_t enum (A_CHAR, Z_CHAR, COLON_CHAR, SPACE_CHAR, LF_CHAR).
  - Function code_to_char(logic [4:0]) returning byte.
- The input decoder imports the same package.
- Single module, one FSM plus output register; no sub-module.

Test Plan:
- Encoding values: "aaa"=15'h0000, "you"=15'h51D8, "hhh"=15'h1CE7.
- Single edge (aaa→you, last), byte_ready=1 → bytes "aaa: you\n\n"; 10 bytes on 10 consecutive cycles; encoding_done pulses once after the final LF.
- Grouped: (aaa→you), (aaa→hhh,last) → "aaa: you hhh\n\n"; edge_ready is low while bytes are pending.
- New source: (aaa→you), (you→hhh,last) → "aaa: you\nyou: hhh\n\n".
- Backpressure: toggle byte_ready randomly at 50% on the grouped case → byte_data is stable while stalled; byte sequence identical; loopback through the input decoder yields edges (0x0000→0x51D8), (0x0000→0x1CE7) and decoding_done.
- Edge with a code of 26 in edge_dst → code_error=1 and stays 1 until reset; output byte 8'h7B is emitted.
- Assert rst_n low during DST1 → byte_valid=0 immediately. After release, a fresh edge produces a clean line starting with SRC0.
